systolic_array: RTL and testbench
=================================

Name: systolic_array

Overview:
- Output-stationary MAX_DIM x MAX_DIM systolic matrix multiplier, the compute core of the matrix engine behind the APB register front-end.
- Each cycle it takes one skewed column-slice of A (row operands) and one skewed row-slice of B (column operands).
- Each processing element (PE) accumulates a*b in place; all accumulators are exposed continuously on a flat result bus.
- Sequencing/skewing of operands is the caller's job.

Parameters:
- DATA_WIDTH, 8, operand width in bits.
- MAX_DIM, 2, array dimension N (N x N PEs); legal range 1..8.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- A  input  MAX_DIM*DATA_WIDTH  lane i (bits [i*DATA_WIDTH +: DATA_WIDTH]) feeds row i at PE(i,0).
- B  input  MAX_DIM*DATA_WIDTH  lane j (bits [j*DATA_WIDTH +: DATA_WIDTH]) feeds column j at PE(0,j).
- result  output  MAX_DIM*MAX_DIM*2*DATA_WIDTH  element C(i,j) at bits [(i*MAX_DIM+j)*2*DATA_WIDTH +: 2*DATA_WIDTH].

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high.
- PE(i,j) inputs:
  - a_in = A lane i if j==0, else a_reg of PE(i,j-1).
  - b_in = B lane j if i==0, else b_reg of PE(i-1,j).
- Each rising edge, reset low:
  - acc <= acc + a_in*b_in
  - a_reg <= a_in
  - b_reg <= b_in
- Each rising edge, reset high: acc, a_reg, b_reg all <= 0. Reset dominates any input (including X).
- result is the acc registers directly, with no extra output register.
- Arithmetic:
  - Operands unsigned by default.
  - Product is full 2*DATA_WIDTH.
  - acc is 2*DATA_WIDTH and wraps modulo 2^(2*DATA_WIDTH); no saturation, no overflow flag.
- Input scheduling (caller): A(i,k) is driven on lane i at cycle k+i; B(k,j) on lane j at cycle k+j; zeros elsewhere.
- Latency: with K = N, C(i,j) is final after edge K+i+j. The full matrix is final 3N-2 edges after the first operand edge (4 edges for N=2).
- Accumulation never self-clears. A new product requires reset, which costs one cycle, then fresh operands.
- Reset asserted mid-operation: everything cleared on that edge. In-flight pipeline operands are discarded.
- Zero inputs: accumulators hold; pipeline drains zeros.

Optional Feature:
- Macro SYSTOLIC_SIGNED_EN.
- Defined: operands are two's-complement; product is signed 2*DATA_WIDTH; acc is signed with wrap.
- Undefined: unsigned operation as above.
- Port widths and timing are identical in both builds.

Decomposition:
- Shared package systolic_pkg holds:
  - default DATA_WIDTH/MAX_DIM constants
  - ACC_WIDTH = 2*DATA_WIDTH
  - a function computing a result-bus bit offset from (i,j)
- One natural sub-module: systolic_pe.
  - Contains a/b forwarding registers, multiplier and accumulator.
  - Instantiated N x N by generate loops in systolic_array.

Test Plan:
- Basic 2x2, DATA_WIDTH=8, MAX_DIM=2; reset 2 cycles, then 4 edges:
  - A stimulus: {A1,A0} = {0,1}, {3,2}, {4,0}, {0,0}.
  - B stimulus: {B1,B0} = {0,5}, {6,7}, {0,0}, {0,0}.
  - Required: after edge 4, C00=19, C01=6, C10=43, C11=18.
- Reset mid-operation: assert reset after the second operand edge of the basic test.
  - Required: result==0 on the next edge; a full re-run reproduces 19/6/43/18.
- Wrap: A0=255, B0=255 for two consecutive cycles, other lanes 0.
  - Required: C00 = 130050 mod 65536 = 64514.
- Idle hold: after basic test completes, drive zeros 10 cycles.
  - Required: result unchanged (19/6/43/18).
- Identity: A = 2x2 identity, B = [[9,8],[7,6]], scheduled skewed.
  - Required: C = [[9,8],[7,6]].
- Signed build (SYSTOLIC_SIGNED_EN): A0 = -3 (8'hFD), B0 = 4, single cycle.
  - Required: C00 = 16'hFFF4 (-12); unsigned build gives 16'h03F4.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and helpers for the systolic matrix multiplier.
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_MAX_DIM    = 2;
    localparam int unsigned ACC_WIDTH      = 2 * DEF_DATA_WIDTH;

    // Bit offset of accumulator C(i,j) on the flat result bus.
    function automatic int unsigned result_offset(input int unsigned i,
                                                  input int unsigned j,
                                                  input int unsigned n,
                                                  input int unsigned dw);
        return (i * n + j) * 2 * dw;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one processing element -- operand forwarding registers plus a
// multiply-accumulate. Define SYSTOLIC_SIGNED_EN for two's-complement operands.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
    output logic [DATA_WIDTH-1:0]     a_out,
    output logic [DATA_WIDTH-1:0]     b_out,
    output logic [2*DATA_WIDTH-1:0]   acc
);

    localparam int unsigned ACC_W = 2 * DATA_WIDTH;

    logic [ACC_W-1:0] a_ext_c;
    logic [ACC_W-1:0] b_ext_c;
    logic [ACC_W-1:0] prod_c;

    // Extend operands to accumulator width; a truncated ACC_W x ACC_W product
    // is the exact product modulo 2^ACC_W for both signed and unsigned inputs.
`ifdef SYSTOLIC_SIGNED_EN
    assign a_ext_c = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign b_ext_c = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
`else
    assign a_ext_c = {{DATA_WIDTH{1'b0}}, a_in};
    assign b_ext_c = {{DATA_WIDTH{1'b0}}, b_in};
`endif

    assign prod_c = a_ext_c * b_ext_c;

    // Forward operands to neighbours and accumulate in place (wrapping).
    always_ff @(posedge clk) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_c;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// systolic_array: output-stationary MAX_DIM x MAX_DIM systolic multiplier.
// Caller supplies skewed operands; accumulators are exposed directly on result.
// Define SYSTOLIC_SIGNED_EN for two's-complement arithmetic (same ports/timing).
module systolic_array
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_DIM    = DEF_MAX_DIM
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]         A,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]         B,
    output logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] result
);

    localparam int unsigned ACC_W = 2 * DATA_WIDTH;

    // a_bus[i][j] feeds PE(i,j) from the left; b_bus[i][j] feeds it from above.
    logic [DATA_WIDTH-1:0] a_bus [MAX_DIM][MAX_DIM+1];
    logic [DATA_WIDTH-1:0] b_bus [MAX_DIM+1][MAX_DIM];

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
        assign a_bus[i][0] = A[i*DATA_WIDTH +: DATA_WIDTH];

        // Operands leaving the right edge have no consumer.
        logic unused_a_edge;
        assign unused_a_edge = ^a_bus[i][MAX_DIM];

        for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .a_in  (a_bus[i][j]),
                .b_in  (b_bus[i][j]),
                .a_out (a_bus[i][j+1]),
                .b_out (b_bus[i+1][j]),
                .acc   (result[result_offset(i, j, MAX_DIM, DATA_WIDTH) +: ACC_W])
            );
        end
    end

    for (genvar j = 0; j < MAX_DIM; j++) begin : g_colin
        assign b_bus[0][j] = B[j*DATA_WIDTH +: DATA_WIDTH];

        // Operands leaving the bottom edge have no consumer.
        logic unused_b_edge;
        assign unused_b_edge = ^b_bus[MAX_DIM][j];
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed scoreboard bench for the 2x2 systolic multiplier.
module tb_systolic_array;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 2 * DW;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N*DW-1:0]       a;
    logic [N*DW-1:0]       b;
    logic [N*N*AW-1:0]     result;

    int checks = 0;
    int passed = 0;

    logic [63:0] exp_q  [$];
    string       name_q [$];

    always #5 clk = ~clk;

    systolic_array #(
        .DATA_WIDTH (DW),
        .MAX_DIM    (N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (a),
        .B      (b),
        .result (result)
    );

    // Drive one operand slice and advance through one rising edge.
    task automatic step(input logic [7:0] a1, input logic [7:0] a0,
                        input logic [7:0] b1, input logic [7:0] b0);
        a = {a1, a0};
        b = {b1, b0};
        @(posedge clk);
        #1;
    endtask

    task automatic expect_c(input string nm, input logic [15:0] c00, input logic [15:0] c01,
                            input logic [15:0] c10, input logic [15:0] c11);
        exp_q.push_back({c11, c10, c01, c00});
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(8'd0, 8'd0, 8'd0, 8'd0);
        reset = 1'b0;
    endtask

    task automatic run_basic();
        step(8'd0, 8'd1, 8'd0, 8'd5);
        step(8'd3, 8'd2, 8'd6, 8'd7);
        step(8'd4, 8'd0, 8'd0, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    // Monitor: compare the result bus against each queued expectation.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (result[k*16 +: 16] === e[k*16 +: 16]) passed++;
                else $display("FAIL %s C%0d%0d: got %0d expected %0d",
                              nm, k / 2, k % 2, result[k*16 +: 16], e[k*16 +: 16]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        step(8'd0, 8'd0, 8'd0, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        expect_c("reset", 16'd0, 16'd0, 16'd0, 16'd0);
        reset = 1'b0;

        run_basic();
        expect_c("basic", 16'd19, 16'd6, 16'd43, 16'd18);

        repeat (5) step(8'd0, 8'd0, 8'd0, 8'd0);
        expect_c("idle5", 16'd19, 16'd6, 16'd43, 16'd18);
        repeat (5) step(8'd0, 8'd0, 8'd0, 8'd0);
        expect_c("idle10", 16'd19, 16'd6, 16'd43, 16'd18);

        do_reset();
        step(8'd0, 8'd1, 8'd0, 8'd5);
        step(8'd3, 8'd2, 8'd6, 8'd7);
        expect_c("partial", 16'd19, 16'd6, 16'd15, 16'd0);
        reset = 1'b1;
        step(8'd4, 8'd0, 8'd0, 8'd0);
        expect_c("midreset", 16'd0, 16'd0, 16'd0, 16'd0);
        reset = 1'b0;
        run_basic();
        expect_c("rerun", 16'd19, 16'd6, 16'd43, 16'd18);

        do_reset();
        step(8'd0, 8'd255, 8'd0, 8'd255);
        step(8'd0, 8'd255, 8'd0, 8'd255);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
`ifdef SYSTOLIC_SIGNED_EN
        expect_c("wrap", 16'd2, 16'd0, 16'd0, 16'd0);
`else
        expect_c("wrap", 16'd64514, 16'd0, 16'd0, 16'd0);
`endif

        do_reset();
        step(8'd0, 8'd1, 8'd0, 8'd9);
        step(8'd0, 8'd0, 8'd8, 8'd7);
        step(8'd1, 8'd0, 8'd6, 8'd0);
        step(8'd0, 8'd0, 8'd0, 8'd0);
        expect_c("identity", 16'd9, 16'd8, 16'd7, 16'd6);

        do_reset();
        step(8'd0, 8'hFD, 8'd0, 8'd4);
        repeat (3) step(8'd0, 8'd0, 8'd0, 8'd0);
`ifdef SYSTOLIC_SIGNED_EN
        expect_c("signmul", 16'hFFF4, 16'd0, 16'd0, 16'd0);
`else
        expect_c("signmul", 16'h03F4, 16'd0, 16'd0, 16'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
